// File: rtl/dbg_inst_encoder_if.sv
// Instruction injection bus between the debug encoder and the fetch/if_id injection port.
interface dbg_inst_encoder_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  modport master (output inst_valid, output inst, output inst_addr, input inst_ready);
  modport slave  (input inst_valid, input inst, input inst_addr, output inst_ready);
endinterface

// File: rtl/dbg_inst_encoder.sv
// Turns abstract debug commands into RV32I LUI/ADDI/CSRRW/CSRRS words and feeds them,
// one per handshake, into the core's instruction injection port.
module dbg_inst_encoder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [4:0]  SCRATCH_REG = 5'd31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_type_i,
  input  logic [11:0]               cmd_regno_i,
  input  logic [31:0]               cmd_data_i,
  input  logic                      abort_i,
  dbg_inst_encoder_if.master        inst_if,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned HI_W  = 20;
  localparam int unsigned LO_W  = 12;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CSR_W = 12;

  localparam logic [1:0] CMD_GPR_WR = 2'd0;
  localparam logic [1:0] CMD_CSR_WR = 2'd1;
  localparam logic [1:0] CMD_CSR_RD = 2'd2;

  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_SYS = 7'h73;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EMIT_LUI  = 3'd1,
    EMIT_ADDI = 3'd2,
    EMIT_CSR  = 3'd3,
    FIN       = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [CSR_W-1:0]  csr_q, csr_d;
  logic [LO_W-1:0]   lo_q, lo_d;
  logic [HI_W-1:0]   hi_q, hi_d;
  logic              lui_q, lui_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic [HI_W-1:0]   cmd_hi;

  // Word emitted in a given emit state; the ADDI base is x0 when the LUI was skipped.
  function automatic logic [XLEN-1:0] enc(input state_e st, input logic [1:0] typ,
                                          input logic [REG_W-1:0] rd, input logic [CSR_W-1:0] csr,
                                          input logic [LO_W-1:0] lo, input logic [HI_W-1:0] hi,
                                          input logic lui);
    logic [XLEN-1:0] w;
    w = {12'h000, 5'd0, 3'b000, 5'd0, OP_IMM};
    case (st)
      EMIT_LUI:  w = {hi, rd, OP_LUI};
      EMIT_ADDI: w = {lo, (lui ? rd : 5'd0), 3'b000, rd, OP_IMM};
      EMIT_CSR:  w = (typ == CMD_CSR_WR) ? {csr, SCRATCH_REG, 3'b001, 5'd0, OP_SYS}
                                         : {csr, 5'd0, 3'b010, rd, OP_SYS};
      default:   w = {12'h000, 5'd0, 3'b000, 5'd0, OP_IMM};
    endcase
    return w;
  endfunction

  // Upper immediate pre-compensated for the sign extension of the ADDI immediate.
  assign cmd_hi = cmd_data_i[31:12] + HI_W'(cmd_data_i[11]);
  assign hs     = valid_q & inst_if.inst_ready;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    rd_d    = rd_q;
    csr_d   = csr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    lui_d   = lui_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = 1'b0;

    if (hs) addr_d = addr_q + 32'd4;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && ready_q && !abort_i) begin
          type_d = cmd_type_i;
          csr_d  = cmd_regno_i;
          addr_d = BASE_ADDR;
          case (cmd_type_i)
            CMD_GPR_WR: begin
              rd_d = cmd_regno_i[4:0];
              lo_d = cmd_data_i[11:0];
              hi_d = cmd_hi;
            end
            CMD_CSR_WR: begin
              rd_d = SCRATCH_REG;
              lo_d = cmd_data_i[11:0];
              hi_d = cmd_hi;
            end
            CMD_CSR_RD: begin
              rd_d = cmd_data_i[4:0];
              lo_d = '0;
              hi_d = '0;
            end
            default: begin
              rd_d = '0;
              lo_d = '0;
              hi_d = '0;
            end
          endcase
          lui_d = (hi_d != '0);
          if (cmd_type_i == CMD_GPR_WR && rd_d == '0) begin
            err_d = 1'b1;
          end else if (cmd_type_i == CMD_CSR_RD) begin
            state_d = EMIT_CSR;
          end else begin
            state_d = lui_d ? EMIT_LUI : EMIT_ADDI;
          end
        end
      end
      EMIT_LUI:  if (hs) state_d = EMIT_ADDI;
      EMIT_ADDI: if (hs) state_d = (type_q == CMD_CSR_WR) ? EMIT_CSR : FIN;
      EMIT_CSR:  if (hs) state_d = FIN;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (abort_i && state_q != IDLE) state_d = IDLE;

    // All handshake/status outputs follow directly from the next state.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
    valid_d = (state_d == EMIT_LUI) || (state_d == EMIT_ADDI) || (state_d == EMIT_CSR);
    if (valid_d) inst_d = enc(state_d, type_d, rd_d, csr_d, lo_d, hi_d, lui_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      type_q  <= '0;
      rd_q    <= '0;
      csr_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      lui_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      inst_q  <= '0;
      addr_q  <= BASE_ADDR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      rd_q    <= rd_d;
      csr_q   <= csr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      lui_q   <= lui_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o        = ready_q;
  assign inst_if.inst_valid = valid_q;
  assign inst_if.inst       = inst_q;
  assign inst_if.inst_addr  = addr_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_dbg_inst_encoder.sv
// Randomized bench for dbg_inst_encoder: a spec-level model lists the expected instruction
// stream per command and a randomly stalling consumer checks every word and address.
module tb_dbg_inst_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [11:0] cmd_regno;
  logic [31:0] cmd_data;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;

  dbg_inst_encoder_if bus ();

  dbg_inst_encoder #(.BASE_ADDR(BASE), .SCRATCH_REG(5'd31)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_type_i  (cmd_type),
    .cmd_regno_i (cmd_regno),
    .cmd_data_i  (cmd_data),
    .abort_i     (abort),
    .inst_if     (bus),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference encodings built from field weights.
  function automatic logic [31:0] w_lui(input int unsigned hi, input int unsigned rd);
    return 32'(hi * 32'h1000 + rd * 128 + 32'h37);
  endfunction
  function automatic logic [31:0] w_addi(input int unsigned imm, input int unsigned rs1, input int unsigned rd);
    return 32'(imm * 32'h10_0000 + rs1 * 32'h8000 + rd * 128 + 32'h13);
  endfunction
  function automatic logic [31:0] w_csrrw(input int unsigned csr, input int unsigned rs1);
    return 32'(csr * 32'h10_0000 + rs1 * 32'h8000 + 32'h1000 + 32'h73);
  endfunction
  function automatic logic [31:0] w_csrrs(input int unsigned csr, input int unsigned rd);
    return 32'(csr * 32'h10_0000 + 32'h2000 + rd * 128 + 32'h73);
  endfunction

  logic [31:0] exp_q[$];
  bit          exp_err;

  // Expected instruction list: hi is bits 31:12 of (data + 0x800), i.e. rounded for ADDI.
  function automatic void model(input logic [1:0] t, input logic [11:0] regno, input logic [31:0] data);
    int unsigned lo, hi, rd;
    logic [31:0] sum;
    exp_q.delete();
    exp_err = 1'b0;
    sum = data + 32'h800;
    lo  = data % 4096;
    hi  = sum / 4096;
    case (t)
      2'd0, 2'd1: begin
        rd = (t == 2'd0) ? regno % 32 : 31;
        if (rd == 0) begin
          exp_err = 1'b1;
        end else begin
          if (hi != 0) exp_q.push_back(w_lui(hi, rd));
          exp_q.push_back(w_addi(lo, (hi != 0) ? rd : 0, rd));
          if (t == 2'd1) exp_q.push_back(w_csrrw(regno, 31));
        end
      end
      2'd2:    exp_q.push_back(w_csrrs(regno, data % 32));
      default: exp_q.push_back(32'h0000_0013);
    endcase
  endfunction

  task automatic send_cmd(input logic [1:0] t, input logic [11:0] regno, input logic [31:0] data,
                          output bit ok);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      ok = 1'b0;
      return;
    end
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_regno = regno;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [11:0] regno, input logic [31:0] data,
                         input int abort_at, input int stall, input int ready_pct);
    bit ok;
    bit rdy;
    int idx = 0;
    int cyc = 0;
    model(t, regno, data);
    send_cmd(t, regno, data, ok);
    if (!ok) return;
    if (exp_err) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_no_valid", 32'(bus.inst_valid), 32'd0);
      chk("err_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("err_one_cycle", 32'(err), 32'd0);
      return;
    end
    chk("err_quiet", 32'(err), 32'd0);
    while (idx < exp_q.size() && cyc < 300) begin
      chk("valid", 32'(bus.inst_valid), 32'd1);
      chk("inst", bus.inst, exp_q[idx]);
      chk("addr", bus.inst_addr, BASE + 32'(4 * idx));
      chk("busy", 32'(busy), 32'd1);
      rdy = (cyc >= stall) && ($urandom_range(99) < ready_pct);
      bus.inst_ready = rdy;
      if (idx == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.inst_ready = 1'b0;
        chk("abort_valid", 32'(bus.inst_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        return;
      end
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    bus.inst_ready = 1'b0;
    if (idx < exp_q.size()) begin
      chk("inst_timeout", 32'(idx), 32'(exp_q.size()));
      return;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("fin_valid", 32'(bus.inst_valid), 32'd0);
    chk("fin_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit          ok;
    logic [1:0]  t;
    logic [11:0] regno;
    logic [31:0] data;
    int          ab;

    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_type = '0;
    cmd_regno = '0;
    cmd_data = '0;
    abort = 1'b0;
    bus.inst_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_addr", bus.inst_addr, BASE);
    @(negedge clk);
    rst = 1'b1;

    run_cmd(2'd0, 12'd5,     32'h1234_5678, -1, 0, 100);
    run_cmd(2'd0, 12'd1,     32'h0000_0800, -1, 0, 100);
    run_cmd(2'd0, 12'd10,    32'h0000_07FF, -1, 0, 100);
    run_cmd(2'd1, 12'h341,   32'hFFFF_FFFF, -1, 0, 100);
    run_cmd(2'd2, 12'h300,   32'h0000_0006, -1, 3, 100);
    run_cmd(2'd0, 12'd0,     32'h0000_1234, -1, 0, 100);
    run_cmd(2'd1, 12'h305,   32'h1234_5678,  1, 0, 100);
    run_cmd(2'd3, 12'h000,   32'h0000_0000, -1, 1, 100);
    run_cmd(2'd0, 12'd7,     32'hFFFF_F800, -1, 0, 50);
    run_cmd(2'd1, 12'h7C0,   32'h8000_0000, -1, 2, 60);

    // abort while idle must not be confused with a command acceptance
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = 2'd3;
    abort     = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_valid", 32'(bus.inst_valid), 32'd0);
    chk("idle_abort_ready", 32'(cmd_ready), 32'd1);

    // asynchronous reset in the middle of a command
    model(2'd1, 12'h342, 32'h0ABC_DEF0);
    send_cmd(2'd1, 12'h342, 32'h0ABC_DEF0, ok);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.inst_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_addr", bus.inst_addr, BASE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_after_valid", 32'(bus.inst_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      t     = 2'($urandom_range(3));
      regno = 12'($urandom);
      case ($urandom_range(4))
        0:       data = $urandom & 32'h0000_0FFF;
        1:       data = 32'hFFFF_F000 | ($urandom & 32'h0000_0FFF);
        2:       data = ($urandom & 32'hFFFF_F000) | 32'h0000_0800;
        default: data = $urandom;
      endcase
      ab = ($urandom_range(99) < 15) ? int'($urandom_range(2)) : -1;
      run_cmd(t, regno, data, ab, int'($urandom_range(2)), int'($urandom_range(100, 40)));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
